// File: rtl/vga_buffer_ctrl_if.sv
// vga_buffer_ctrl_if
// Groups the host write/read handshakes, the bulk-engine command handshake and
// the buffer-side access port of vga_buffer_ctrl into one bundle.
// Signal suffixes (_i/_o) are from the controller's point of view.
//   slave  : controller side (vga_buffer_ctrl)
//   master : host, command source and buffer side (testbench / surrounding logic)
`timescale 1ns/1ps

interface vga_buffer_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 28,
    parameter int CHAR_WIDTH = 7,
    parameter int STRB_WIDTH = 4
) ();
    logic                  host_wr_valid_i;
    logic                  host_wr_ready_o;
    logic [ADDR_WIDTH-1:0] host_w_addr_i;
    logic [STRB_WIDTH-1:0] host_w_strb_i;
    logic [DATA_WIDTH-1:0] host_din_i;
    logic                  host_rd_valid_i;
    logic                  host_rd_ready_o;
    logic [ADDR_WIDTH-1:0] host_r_addr_i;
    logic [DATA_WIDTH-1:0] host_rd_data_o;
    logic                  host_rd_dvalid_o;
    logic                  cmd_valid_i;
    logic [1:0]            cmd_op_i;
    logic [CHAR_WIDTH-1:0] cmd_fill_i;
    logic                  cmd_ready_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  buf_wr_en_o;
    logic [ADDR_WIDTH-1:0] buf_w_addr_o;
    logic [STRB_WIDTH-1:0] buf_w_strb_o;
    logic [DATA_WIDTH-1:0] buf_din_o;
    logic                  buf_r_req_o;
    logic [ADDR_WIDTH-1:0] buf_r_addr_o;
    logic [DATA_WIDTH-1:0] buf_r_data_i;

    modport slave (
        input  host_wr_valid_i, host_w_addr_i, host_w_strb_i, host_din_i,
        input  host_rd_valid_i, host_r_addr_i,
        input  cmd_valid_i, cmd_op_i, cmd_fill_i,
        input  buf_r_data_i,
        output host_wr_ready_o, host_rd_ready_o, host_rd_data_o, host_rd_dvalid_o,
        output cmd_ready_o, busy_o, done_o,
        output buf_wr_en_o, buf_w_addr_o, buf_w_strb_o, buf_din_o,
        output buf_r_req_o, buf_r_addr_o
    );

    modport master (
        output host_wr_valid_i, host_w_addr_i, host_w_strb_i, host_din_i,
        output host_rd_valid_i, host_r_addr_i,
        output cmd_valid_i, cmd_op_i, cmd_fill_i,
        output buf_r_data_i,
        input  host_wr_ready_o, host_rd_ready_o, host_rd_data_o, host_rd_dvalid_o,
        input  cmd_ready_o, busy_o, done_o,
        input  buf_wr_en_o, buf_w_addr_o, buf_w_strb_o, buf_din_o,
        input  buf_r_req_o, buf_r_addr_o
    );
endinterface

// File: rtl/vga_buffer_ctrl.sv
// vga_buffer_ctrl
// Access sequencer/arbiter in front of the screen-tile buffer's write/read port.
// One buffer access per cycle, shared between the host path and a bulk engine
// (clear, scroll-up-one-row, optional fill).
// Ports:
//   clk_i  : 25 MHz clock
//   rstn_i : async active-low reset
//   bus    : vga_buffer_ctrl_if.slave (host write/read, engine command, buffer port)
// Build option:
//   VGA_CTRL_FILL_EN defined   -> op 10 fills every word with {4{cmd_fill_i}}
//   VGA_CTRL_FILL_EN undefined -> op 10 is a clear, cmd_fill_i ignored
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready_o high
// ST_CLR     | writing 0 to addr_q, advances per engine grant
// ST_FILL    | writing the fill pattern to addr_q, advances per engine grant
// ST_SCR_RD  | reading addr_q + ROW_WORDS
// ST_SCR_LAT | read data arriving, captured into hold_q (no request)
// ST_SCR_WR  | writing hold_q to addr_q
// ST_SCR_CLR | writing 0 to the bottom row
// ST_DONE    | one-cycle done_o pulse
`timescale 1ns/1ps

module vga_buffer_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 28,
    parameter int CHAR_WIDTH = 7,
    parameter int NUM_ADDRS  = 600,
    parameter int ROW_WORDS  = 20,
    parameter int STRB_WIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    vga_buffer_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CLR, ST_FILL, ST_SCR_RD, ST_SCR_LAT, ST_SCR_WR, ST_SCR_CLR, ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDRS - 1);
    localparam logic [ADDR_WIDTH-1:0] SCR_LAST  = ADDR_WIDTH'(NUM_ADDRS - ROW_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_OFS   = ADDR_WIDTH'(ROW_WORDS);
    localparam logic [STRB_WIDTH-1:0] STRB_ALL  = {STRB_WIDTH{1'b1}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  last_eng_q, last_eng_d;   // 0: host won the last contention
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
`ifdef VGA_CTRL_FILL_EN
    logic [CHAR_WIDTH-1:0] fill_q, fill_d;
`else
    logic                  unused_fill;
    assign unused_fill = ^bus.cmd_fill_i;
`endif

    logic                  eng_req, host_req, eng_gnt, host_wr_gnt, host_rd_gnt;
    logic                  buf_wr_en, buf_r_req;
    logic [ADDR_WIDTH-1:0] buf_w_addr, buf_r_addr;
    logic [STRB_WIDTH-1:0] buf_w_strb;
    logic [DATA_WIDTH-1:0] buf_din;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            hold_q     <= '0;
            last_eng_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_data_q  <= '0;
`ifdef VGA_CTRL_FILL_EN
            fill_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            last_eng_q <= last_eng_d;
            rd_pend_q  <= rd_pend_d;
            rd_data_q  <= rd_data_d;
`ifdef VGA_CTRL_FILL_EN
            fill_q     <= fill_d;
`endif
        end
    end

    // Arbitration and buffer-side mux
    always_comb begin
        eng_req = (state_q == ST_CLR) || (state_q == ST_FILL) || (state_q == ST_SCR_RD) ||
                  (state_q == ST_SCR_WR) || (state_q == ST_SCR_CLR);
        // Host requests are masked while reset is asserted so no write escapes.
        host_req = rstn_i & (bus.host_wr_valid_i | bus.host_rd_valid_i);
        last_eng_d = last_eng_q;
        if (eng_req && host_req) begin
            eng_gnt    = !last_eng_q;
            last_eng_d = eng_gnt;
        end else begin
            eng_gnt = eng_req;
        end
        host_wr_gnt = host_req & !eng_gnt & bus.host_wr_valid_i;
        host_rd_gnt = host_req & !eng_gnt & !bus.host_wr_valid_i;

        buf_wr_en  = 1'b0;
        buf_w_addr = '0;
        buf_w_strb = '0;
        buf_din    = '0;
        buf_r_req  = 1'b0;
        buf_r_addr = '0;
        if (host_wr_gnt) begin
            buf_wr_en  = 1'b1;
            buf_w_addr = bus.host_w_addr_i;
            buf_w_strb = bus.host_w_strb_i;
            buf_din    = bus.host_din_i;
        end else if (host_rd_gnt) begin
            buf_r_req  = 1'b1;
            buf_r_addr = bus.host_r_addr_i;
        end else if (eng_gnt) begin
            if (state_q == ST_SCR_RD) begin
                buf_r_req  = 1'b1;
                buf_r_addr = addr_q + ROW_OFS;
            end else begin
                buf_wr_en  = 1'b1;
                buf_w_addr = addr_q;
                buf_w_strb = STRB_ALL;
                if (state_q == ST_SCR_WR) buf_din = hold_q;
`ifdef VGA_CTRL_FILL_EN
                if (state_q == ST_FILL) buf_din = DATA_WIDTH'({4{fill_q}});
`endif
            end
        end

        rd_pend_d = host_rd_gnt;
        rd_data_d = rd_pend_q ? bus.buf_r_data_i : rd_data_q;
    end

    // Engine sequencing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
`ifdef VGA_CTRL_FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    addr_d = '0;
`ifdef VGA_CTRL_FILL_EN
                    fill_d = bus.cmd_fill_i;
`endif
                    case (bus.cmd_op_i)
                        2'b00:   state_d = ST_CLR;
                        2'b01:   state_d = ST_SCR_RD;
`ifdef VGA_CTRL_FILL_EN
                        2'b10:   state_d = ST_FILL;
`else
                        2'b10:   state_d = ST_CLR;
`endif
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_CLR, ST_FILL, ST_SCR_CLR: begin
                if (eng_gnt) begin
                    if (addr_q == LAST_ADDR) state_d = ST_DONE;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            ST_SCR_RD: begin
                if (eng_gnt) state_d = ST_SCR_LAT;
            end
            ST_SCR_LAT: begin
                hold_d  = bus.buf_r_data_i;
                state_d = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                if (eng_gnt) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = (addr_q == SCR_LAST) ? ST_SCR_CLR : ST_SCR_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.host_wr_ready_o  = host_wr_gnt;
    assign bus.host_rd_ready_o  = host_rd_gnt;
    assign bus.host_rd_dvalid_o = rd_pend_q;
    assign bus.host_rd_data_o   = rd_pend_q ? bus.buf_r_data_i : rd_data_q;
    assign bus.cmd_ready_o      = (state_q == ST_IDLE);
    assign bus.busy_o           = (state_q != ST_IDLE);
    assign bus.done_o           = (state_q == ST_DONE);
    assign bus.buf_wr_en_o      = buf_wr_en;
    assign bus.buf_w_addr_o     = buf_w_addr;
    assign bus.buf_w_strb_o     = buf_w_strb;
    assign bus.buf_din_o        = buf_din;
    assign bus.buf_r_req_o      = buf_r_req;
    assign bus.buf_r_addr_o     = buf_r_addr;
endmodule

// File: tb/tb_vga_buffer_ctrl.sv
`timescale 1ns/1ps

module tb_vga_buffer_ctrl;
    localparam int AW = 10, DW = 28, CW = 7, NA = 600, RW = 20, SW = 4;
`ifdef VGA_CTRL_FILL_EN
    localparam logic [DW-1:0] FILL_EXP = 28'h83060C1;
`else
    localparam logic [DW-1:0] FILL_EXP = 28'h0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #20 clk = ~clk;

    vga_buffer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHAR_WIDTH(CW), .STRB_WIDTH(SW)) bus ();
    vga_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHAR_WIDTH(CW), .NUM_ADDRS(NA),
                      .ROW_WORDS(RW), .STRB_WIDTH(SW)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

    int total = 0;
    int bad = 0;

    // Buffer model: strobed writes, read data the cycle after r_req.
    logic [DW-1:0] mem [NA];
    int wr_cnt = 0;
    int oob = 0;
    always @(posedge clk) begin
        if (bus.buf_wr_en_o) begin
            wr_cnt = wr_cnt + 1;
            if (int'(bus.buf_w_addr_o) < NA) begin
                for (int b = 0; b < SW; b++)
                    if (bus.buf_w_strb_o[b]) mem[bus.buf_w_addr_o][b*CW +: CW] = bus.buf_din_o[b*CW +: CW];
            end else oob = oob + 1;
        end
        if (bus.buf_r_req_o) begin
            if (int'(bus.buf_r_addr_o) < NA) bus.buf_r_data_i <= mem[bus.buf_r_addr_o];
            else oob = oob + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr_v;
        logic          rd_v;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [DW-1:0] din;
        logic [SW-1:0] strb;
        logic          e_wrdy;
        logic          e_rrdy;
    } vec_t;
    vec_t vt [5];

    // Results of the last run_cmd
    int busy_cyc, eng_wr, eng_rd, seq_err, alt_err, host_done, last_wr_cyc, done_cyc;
    logic got_done;
    logic [DW-1:0] first_din;

    task automatic start_cmd(input logic [1:0] op, input logic [CW-1:0] fill);
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_fill_i  = fill;
        @(posedge clk);
    endtask

    // Runs one command; stop_addr >= 0 leaves the loop when the engine writes that address.
    task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] fill, input int n_host,
                           input bit hold_cmd, input bit chk_din, input logic [DW-1:0] exp_din,
                           input int stop_addr);
        int hidx, exp_addr;
        bit have_prev, prev_host;
        busy_cyc = 0; eng_wr = 0; eng_rd = 0; seq_err = 0; alt_err = 0;
        last_wr_cyc = -1; done_cyc = -1; got_done = 1'b0; first_din = 'x;
        hidx = 0; exp_addr = 0; have_prev = 0; prev_host = 1;
        start_cmd(op, fill);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!hold_cmd) bus.cmd_valid_i = 1'b0;
            bus.host_wr_valid_i = (hidx < n_host);
            bus.host_w_addr_i   = AW'(200 + hidx);
            bus.host_din_i      = DW'(hidx + 1);
            bus.host_w_strb_i   = 4'hF;
            #1;
            if (bus.busy_o) busy_cyc++;
            if (bus.cmd_ready_o === bus.busy_o) seq_err++;
            if (bus.host_wr_valid_i && bus.busy_o && !bus.done_o) begin
                // first contention after reset goes to the engine, then alternates
                if (bus.host_wr_ready_o == (have_prev ? prev_host : 1'b1)) alt_err++;
                prev_host = bus.host_wr_ready_o;
                have_prev = 1;
            end
            if (bus.buf_wr_en_o && !bus.host_wr_ready_o) begin
                if (eng_wr == 0) first_din = bus.buf_din_o;
                if (int'(bus.buf_w_addr_o) != exp_addr) seq_err++;
                if (bus.buf_w_strb_o !== 4'hF) seq_err++;
                if (chk_din && bus.buf_din_o !== exp_din) seq_err++;
                exp_addr++;
                eng_wr++;
                last_wr_cyc = cyc;
                if (int'(bus.buf_w_addr_o) == stop_addr) break;
            end
            if (bus.buf_r_req_o && !bus.host_rd_ready_o) eng_rd++;
            if (bus.host_wr_ready_o) hidx++;
            if (bus.done_o) begin
                done_cyc = cyc;
                got_done = 1'b1;
                break;
            end
        end
        host_done = hidx;
        bus.cmd_valid_i     = 1'b0;
        bus.host_wr_valid_i = 1'b0;
        if (stop_addr < 0) check("done_seen", {31'd0, got_done}, 32'd1);
    endtask

    int cnt, exp_cnt;
    logic [DW-1:0] orig [NA];

    initial begin
        bus.host_wr_valid_i = 0; bus.host_w_addr_i = 0; bus.host_w_strb_i = 0; bus.host_din_i = 0;
        bus.host_rd_valid_i = 0; bus.host_r_addr_i = 0;
        bus.cmd_valid_i = 0; bus.cmd_op_i = 0; bus.cmd_fill_i = 0;
        for (int i = 0; i < NA; i++) mem[i] = '0;

        // Reset values
        #5;
        check("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_done", {31'd0, bus.done_o}, 32'd0);
        check("rst_wr_en", {31'd0, bus.buf_wr_en_o}, 32'd0);
        check("rst_r_req", {31'd0, bus.buf_r_req_o}, 32'd0);
        check("rst_rd_dvalid", {31'd0, bus.host_rd_dvalid_o}, 32'd0);
        check("rst_rd_data", 32'(bus.host_rd_data_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Host-only access vectors, engine idle
        vt[0] = '{0, 0, 10'd0,  10'd0, 28'h0,       4'hF, 0, 0};
        vt[1] = '{1, 0, 10'd7,  10'd0, 28'h1111111, 4'hF, 1, 0};
        vt[2] = '{0, 1, 10'd0,  10'd7, 28'h0,       4'hF, 0, 1};
        vt[3] = '{1, 1, 10'd8,  10'd9, 28'h2222222, 4'hF, 1, 0};
        vt[4] = '{1, 0, 10'd10, 10'd0, 28'hFFFFFFF, 4'h5, 1, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.host_wr_valid_i = vt[i].wr_v;
            bus.host_rd_valid_i = vt[i].rd_v;
            bus.host_w_addr_i   = vt[i].wa;
            bus.host_r_addr_i   = vt[i].ra;
            bus.host_din_i      = vt[i].din;
            bus.host_w_strb_i   = vt[i].strb;
            #1;
            check($sformatf("vec%0d_wr_ready", i), {31'd0, bus.host_wr_ready_o}, {31'd0, vt[i].e_wrdy});
            check($sformatf("vec%0d_rd_ready", i), {31'd0, bus.host_rd_ready_o}, {31'd0, vt[i].e_rrdy});
            check($sformatf("vec%0d_wr_en", i), {31'd0, bus.buf_wr_en_o}, {31'd0, vt[i].e_wrdy});
            check($sformatf("vec%0d_r_req", i), {31'd0, bus.buf_r_req_o}, {31'd0, vt[i].e_rrdy});
            if (vt[i].e_wrdy) begin
                check($sformatf("vec%0d_w_addr", i), 32'(bus.buf_w_addr_o), 32'(vt[i].wa));
                check($sformatf("vec%0d_din", i), 32'(bus.buf_din_o), 32'(vt[i].din));
                check($sformatf("vec%0d_strb", i), 32'(bus.buf_w_strb_o), 32'(vt[i].strb));
            end
            if (vt[i].e_rrdy) check($sformatf("vec%0d_r_addr", i), 32'(bus.buf_r_addr_o), 32'(vt[i].ra));
        end
        @(negedge clk);
        bus.host_wr_valid_i = 0; bus.host_rd_valid_i = 0;
        check("mem7_written", 32'(mem[7]), 32'h1111111);
        check("mem10_strobed", 32'(mem[10]), 32'h01FC07F);

        // Clear, host idle, cmd_valid held throughout (must not restart the sweep)
        for (int i = 0; i < NA; i++) mem[i] = DW'(i + 1);
        run_cmd(2'b00, 7'h0, 0, 1, 1, 28'h0, -1);
        check("clr_seq", 32'(seq_err), 0);
        check("clr_writes", 32'(eng_wr), 32'd600);
        check("clr_busy", 32'(busy_cyc), 32'd601);
        check("clr_done_timing", 32'(done_cyc), 32'(last_wr_cyc + 1));
        cnt = 0;
        for (int i = 0; i < NA; i++) if (mem[i] !== '0) cnt++;
        check("clr_mem_zero", 32'(cnt), 0);
        @(negedge clk); #1;
        check("clr_idle_after", {31'd0, bus.cmd_ready_o}, 32'd1);

        // Clear with host write contention
        run_cmd(2'b00, 7'h0, 10, 0, 1, 28'h0, -1);
        check("cont_alternate", 32'(alt_err), 0);
        check("cont_host_done", 32'(host_done), 32'd10);
        check("cont_eng_writes", 32'(eng_wr), 32'd600);
        check("cont_seq", 32'(seq_err), 0);
        check("cont_busy", 32'(busy_cyc), 32'd611);

        // Scroll up one row
        for (int i = 0; i < NA; i++) mem[i] = DW'(28'h100000 + i);
        mem[20] = 28'h1234567;
        mem[599] = 28'h7654321;
        for (int i = 0; i < NA; i++) orig[i] = mem[i];
        run_cmd(2'b01, 7'h0, 0, 0, 0, 28'h0, -1);
        check("scr_seq", 32'(seq_err), 0);
        check("scr_writes", 32'(eng_wr), 32'd600);
        check("scr_reads", 32'(eng_rd), 32'd580);
        check("scr_done_timing", 32'(done_cyc), 32'(last_wr_cyc + 1));
        check("scr_mem0", 32'(mem[0]), 32'h1234567);
        check("scr_mem579", 32'(mem[579]), 32'h7654321);
        cnt = 0;
        for (int i = 0; i < 580; i++) if (mem[i] !== orig[i+20]) cnt++;
        check("scr_shifted", 32'(cnt), 0);
        cnt = 0;
        for (int i = 580; i < NA; i++) if (mem[i] !== '0) cnt++;
        check("scr_bottom_zero", 32'(cnt), 0);

        // Host read with engine idle
        mem[5] = 28'hABCDEF0;
        @(negedge clk);
        bus.host_rd_valid_i = 1; bus.host_r_addr_i = 10'd5;
        #1;
        check("rd_ready", {31'd0, bus.host_rd_ready_o}, 32'd1);
        check("rd_r_addr", 32'(bus.buf_r_addr_o), 32'd5);
        check("rd_dvalid_early", {31'd0, bus.host_rd_dvalid_o}, 32'd0);
        @(negedge clk);
        bus.host_rd_valid_i = 0;
        #1;
        check("rd_dvalid", {31'd0, bus.host_rd_dvalid_o}, 32'd1);
        check("rd_data", 32'(bus.host_rd_data_o), 32'hABCDEF0);
        @(negedge clk); #1;
        check("rd_dvalid_pulse", {31'd0, bus.host_rd_dvalid_o}, 32'd0);
        check("rd_data_hold", 32'(bus.host_rd_data_o), 32'hABCDEF0);

        // Reserved op: no access, done next cycle
        cnt = wr_cnt;
        start_cmd(2'b11, 7'h0);
        @(negedge clk);
        bus.cmd_valid_i = 0;
        #1;
        check("op3_done", {31'd0, bus.done_o}, 32'd1);
        @(negedge clk); #1;
        check("op3_idle", {31'd0, bus.cmd_ready_o}, 32'd1);
        check("op3_no_writes", 32'(wr_cnt - cnt), 0);

        // Fill (or clear when the feature is not built in)
        for (int i = 0; i < NA; i++) mem[i] = 28'h5555555;
        run_cmd(2'b10, 7'h41, 0, 0, 1, FILL_EXP, -1);
        check("fill_first_din", 32'(first_din), 32'(FILL_EXP));
        check("fill_seq", 32'(seq_err), 0);
        cnt = 0;
        for (int i = 0; i < NA; i++) if (mem[i] !== FILL_EXP) cnt++;
        check("fill_mem", 32'(cnt), 0);

        // Async reset in the middle of a clear
        run_cmd(2'b00, 7'h0, 0, 0, 1, 28'h0, 300);
        check("rst_mid_reached", 32'(eng_wr), 32'd301);
        rstn = 1'b0;
        #1;
        check("rst_mid_wr_en", {31'd0, bus.buf_wr_en_o}, 32'd0);
        check("rst_mid_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        cnt = wr_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_no_writes", 32'(wr_cnt - cnt), 0);
        rstn = 1'b1;
        #1;
        check("rst_rel_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        run_cmd(2'b00, 7'h0, 0, 0, 1, 28'h0, -1);
        check("rst_reclr_seq", 32'(seq_err), 0);
        check("rst_reclr_writes", 32'(eng_wr), 32'd600);
        check("rst_reclr_busy", 32'(busy_cyc), 32'd601);

        check("addr_in_range", 32'(oob), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
